// File: rtl/sbus2a.sv
// sbus2a: SBUS beat stream to AXI4-Stream master through a store-and-forward packet FIFO.
// Define SBUS2A_DROP_CNT_EN to add the DROP_CNT port and its saturating drop counter.
module sbus2a #(
  parameter int TDATA_WIDTH = 256,
  parameter int FIFO_DEPTH  = 64,
  parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     S_SBUS_VALID,
  input  logic [TDATA_WIDTH-1:0]   S_SBUS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_SBUS_TKEEP,
  input  logic [7:0]               S_SBUS_CTL,
  output logic                     M_AXIS_TVALID,
  output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                     M_AXIS_TLAST,
  input  logic                     M_AXIS_TREADY,
  output logic                     PKT_DROP
`ifdef SBUS2A_DROP_CNT_EN
  ,
  output logic [31:0]              DROP_CNT
`endif
);

  localparam int KeepWidth = TDATA_WIDTH / 8;
  localparam int MemWidth  = 1 + KeepWidth + TDATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthPtr = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StPkt, StDrop} wr_state_e;

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_q, wr_d;
  logic [ADDR_WIDTH:0]   commit_q, commit_d;
  logic [ADDR_WIDTH:0]   rd_q;
  logic [ADDR_WIDTH:0]   wr_base;
  logic                  drop_q, drop_d;
  logic                  wr_en;
  logic                  full;
  logic                  sop, eop;
  logic                  rd_load;

  logic [MemWidth-1:0]   mem [FIFO_DEPTH];
  logic [MemWidth-1:0]   rd_entry;

  logic                  tvalid_q;
  logic                  tlast_q;
  logic [KeepWidth-1:0]  tkeep_q;
  logic [TDATA_WIDTH-1:0] tdata_q;

  logic                  unused_ctl;

  assign sop        = S_SBUS_CTL[0];
  assign eop        = S_SBUS_CTL[1];
  assign unused_ctl = ^S_SBUS_CTL[7:2];

  // A SOP arriving mid-packet discards the open packet first, so its space check and
  // write address start from the last committed position.
  assign wr_base = (state_q == StPkt && sop) ? commit_q : wr_q;
  assign full    = (wr_base - rd_q) == DepthPtr;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    commit_d = commit_q;
    drop_d   = 1'b0;
    wr_en    = 1'b0;
    if (S_SBUS_VALID) begin
      if (sop) begin
        if (state_q == StPkt) begin
          drop_d = 1'b1;
          wr_d   = commit_q;
        end
        if (full) begin
          drop_d  = 1'b1;
          state_d = eop ? StIdle : StDrop;
        end else begin
          wr_en = 1'b1;
          wr_d  = wr_base + 1'b1;
          if (eop) begin
            commit_d = wr_base + 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StPkt;
          end
        end
      end else begin
        unique case (state_q)
          StIdle: drop_d = 1'b1;
          StPkt: begin
            if (full) begin
              wr_d    = commit_q;
              drop_d  = 1'b1;
              state_d = eop ? StIdle : StDrop;
            end else begin
              wr_en = 1'b1;
              wr_d  = wr_q + 1'b1;
              if (eop) begin
                commit_d = wr_q + 1'b1;
                state_d  = StIdle;
              end
            end
          end
          StDrop: if (eop) state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= StIdle;
      wr_q     <= '0;
      commit_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem[wr_base[ADDR_WIDTH-1:0]] <= {eop, S_SBUS_TKEEP, S_SBUS_TDATA};
    end
  end

  assign rd_entry = mem[rd_q[ADDR_WIDTH-1:0]];
  assign rd_load  = (rd_q != commit_q) && (!tvalid_q || M_AXIS_TREADY);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_q     <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
      tdata_q  <= '0;
    end else if (rd_load) begin
      rd_q     <= rd_q + 1'b1;
      tvalid_q <= 1'b1;
      tlast_q  <= rd_entry[MemWidth-1];
      tkeep_q  <= rd_entry[TDATA_WIDTH +: KeepWidth];
      tdata_q  <= rd_entry[TDATA_WIDTH-1:0];
    end else if (tvalid_q && M_AXIS_TREADY) begin
      tvalid_q <= 1'b0;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TKEEP  = tkeep_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign PKT_DROP      = drop_q;

`ifdef SBUS2A_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      drop_cnt_q <= '0;
    end else if (drop_d && drop_cnt_q != 32'hFFFF_FFFF) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  a_axis_stable: assert property (@(posedge ACLK) disable iff (ARESET)
    (M_AXIS_TVALID && !M_AXIS_TREADY) |=>
      (M_AXIS_TVALID && $stable({M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA})));

  a_occupancy: assert property (@(posedge ACLK) disable iff (ARESET)
    (wr_q - rd_q) <= DepthPtr);

  a_commit_order: assert property (@(posedge ACLK) disable iff (ARESET)
    (commit_q - rd_q) <= (wr_q - rd_q));

endmodule

// File: tb/tb_sbus2a.sv
// Randomized and directed bench for sbus2a against a queue-based packet model.
module tb_sbus2a;
  localparam int W = 256;
  localparam int K = W / 8;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          S_SBUS_VALID = 1'b0;
  logic [W-1:0]  S_SBUS_TDATA = '0;
  logic [K-1:0]  S_SBUS_TKEEP = '0;
  logic [7:0]    S_SBUS_CTL = '0;
  logic          M_AXIS_TVALID;
  logic [W-1:0]  M_AXIS_TDATA;
  logic [K-1:0]  M_AXIS_TKEEP;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b0;
  logic          PKT_DROP;
`ifdef SBUS2A_DROP_CNT_EN
  logic [31:0]   DROP_CNT;
`endif

  sbus2a #(.TDATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .ACLK(clk),
    .ARESET(rst),
    .S_SBUS_VALID(S_SBUS_VALID),
    .S_SBUS_TDATA(S_SBUS_TDATA),
    .S_SBUS_TKEEP(S_SBUS_TKEEP),
    .S_SBUS_CTL(S_SBUS_CTL),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .PKT_DROP(PKT_DROP)
`ifdef SBUS2A_DROP_CNT_EN
    ,
    .DROP_CNT(DROP_CNT)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         last;
    logic [K-1:0] keep;
    logic [W-1:0] data;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: committed packets and the packet under construction as beat queues.
  beat_t       committed[$];
  beat_t       open_q[$];
  beat_t       out_m;
  bit          outv_m, drop_m, in_pkt, discarding;
  logic [31:0] cnt_m;

  task automatic model_reset();
    committed.delete();
    open_q.delete();
    out_m = '0;
    outv_m = 0; drop_m = 0; in_pkt = 0; discarding = 0;
    cnt_m = '0;
  endtask

  task automatic commit_open();
    while (open_q.size() > 0) committed.push_back(open_q.pop_front());
  endtask

  task automatic model_step(input bit v, input logic [7:0] ctl, input logic [K-1:0] keep,
                            input logic [W-1:0] data, input bit rdy);
    bit sop, eop, full_pre, full_rw, full, drop;
    beat_t b;
    sop = ctl[0];
    eop = ctl[1];
    b = {eop, keep, data};
    full_pre = (committed.size() + open_q.size()) == D;
    full_rw  = committed.size() == D;
    drop = 0;
    // Output side sees only packets committed before this edge.
    if (committed.size() > 0 && (!outv_m || rdy)) begin
      out_m = committed.pop_front();
      outv_m = 1;
    end else if (outv_m && rdy) begin
      outv_m = 0;
    end
    if (v) begin
      if (sop) begin
        full = full_pre;
        if (in_pkt) begin
          open_q.delete();
          drop = 1;
          full = full_rw;
        end
        in_pkt = 0;
        discarding = 0;
        if (full) begin
          drop = 1;
          discarding = !eop;
        end else begin
          open_q.push_back(b);
          if (eop) commit_open();
          else in_pkt = 1;
        end
      end else if (in_pkt) begin
        if (full_pre) begin
          open_q.delete();
          drop = 1;
          in_pkt = 0;
          discarding = !eop;
        end else begin
          open_q.push_back(b);
          if (eop) begin
            commit_open();
            in_pkt = 0;
          end
        end
      end else if (discarding) begin
        if (eop) discarding = 0;
      end else begin
        drop = 1;
      end
    end
    drop_m = drop;
    if (drop && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
  endtask

  // Sampled stimulus and observed-output tallies for directed checks.
  logic         s_valid, s_rdy, s_rst;
  logic [7:0]   s_ctl;
  logic [K-1:0] s_keep;
  logic [W-1:0] s_data;
  int           obs_beats = 0, obs_lasts = 0, obs_drops = 0;
  logic [K-1:0] last_keep = '0;

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      s_valid = S_SBUS_VALID; s_ctl = S_SBUS_CTL; s_keep = S_SBUS_TKEEP;
      s_data = S_SBUS_TDATA; s_rdy = M_AXIS_TREADY; s_rst = rst;
      if (!rst) begin
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          obs_beats++;
          if (M_AXIS_TLAST) begin
            obs_lasts++;
            last_keep = M_AXIS_TKEEP;
          end
        end
        if (PKT_DROP) obs_drops++;
      end
      @(posedge clk);
      if (s_rst) model_reset();
      else model_step(s_valid, s_ctl, s_keep, s_data, s_rdy);
      #1;
      check("tvalid", M_AXIS_TVALID, outv_m);
      if (outv_m) check("beat", {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}, out_m);
      check("pkt_drop", PKT_DROP, drop_m);
`ifdef SBUS2A_DROP_CNT_EN
      check("drop_cnt", DROP_CNT, cnt_m);
`endif
    end
  end

  bit rand_ready = 0;

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input bit v, input logic [7:0] ctl, input logic [K-1:0] keep,
                       input logic [W-1:0] data);
    @(negedge clk);
    S_SBUS_VALID = v;
    S_SBUS_CTL = ctl;
    S_SBUS_TKEEP = keep;
    S_SBUS_TDATA = data;
    if (rand_ready) M_AXIS_TREADY = ($urandom_range(0, 9) < 7);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 8'h00, '0, '0);
  endtask

  task automatic clear_obs();
    obs_beats = 0; obs_lasts = 0; obs_drops = 0; last_keep = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    S_SBUS_VALID = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    clear_obs();
  endtask

  initial begin
    int i;
    logic [7:0] ctl;
    int len;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_tvalid", M_AXIS_TVALID, 0);
    check("rst_axis", {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}, 0);
    check("rst_drop", PKT_DROP, 0);

    // Single-beat packet
    M_AXIS_TREADY = 1;
    drive(1, 8'h03, 32'hFFFF_FFFF, rand_data());
    idle(6);
    check("t1_beats", obs_beats, 1);
    check("t1_last", obs_lasts, 1);
    check("t1_drops", obs_drops, 0);

    // Backpressure
    do_reset();
    M_AXIS_TREADY = 0;
    drive(1, 8'h01, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h00, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h02, 32'h0000_FFFF, rand_data());
    idle(10);
    check("t2_held_valid", M_AXIS_TVALID, 1);
    check("t2_held_beats", obs_beats, 0);
    M_AXIS_TREADY = 1;
    idle(6);
    check("t2_beats", obs_beats, 3);
    check("t2_last", obs_lasts, 1);
    check("t2_keep", last_keep, 32'h0000_FFFF);

    // Overflow: 9-beat packet into an 8-entry FIFO
    do_reset();
    M_AXIS_TREADY = 0;
    for (int b = 0; b < 9; b++) begin
      ctl = (b == 0) ? 8'h01 : ((b == 8) ? 8'h02 : 8'h00);
      drive(1, ctl, 32'hFFFF_FFFF, rand_data());
    end
    idle(4);
    check("t3_drops", obs_drops, 1);
    check("t3_no_out", M_AXIS_TVALID, 0);
    M_AXIS_TREADY = 1;
    drive(1, 8'h01, $urandom, rand_data());
    drive(1, 8'h02, $urandom, rand_data());
    idle(6);
    check("t3_beats", obs_beats, 2);
    check("t3_last", obs_lasts, 1);

    // Abandoned packet
    do_reset();
    M_AXIS_TREADY = 1;
    drive(1, 8'h01, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h00, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h03, 32'h00FF_00FF, rand_data());
    idle(6);
    check("t4_drops", obs_drops, 1);
    check("t4_beats", obs_beats, 1);
    check("t4_keep", last_keep, 32'h00FF_00FF);
`ifdef SBUS2A_DROP_CNT_EN
    check("t4_drop_cnt", DROP_CNT, 1);
`endif

    // Orphan beat, then reset during delivery
    do_reset();
    drive(1, 8'h00, 32'hFFFF_FFFF, rand_data());
    idle(3);
    check("t5_drops", obs_drops, 1);
    check("t5_no_out", obs_beats, 0);
    drive(1, 8'h01, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h00, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h00, 32'hFFFF_FFFF, rand_data());
    drive(1, 8'h02, 32'hFFFF_FFFF, rand_data());
    for (i = 0; i < 20 && !M_AXIS_TVALID; i++) idle(1);
    check("t5_wait_tvalid", (i < 20), 1);
    @(negedge clk);
    rst = 1;
    #1;
    check("t5_rst_tvalid", M_AXIS_TVALID, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    clear_obs();
    idle(10);
    check("t5_after_rst", obs_beats, 0);
`ifdef SBUS2A_DROP_CNT_EN
    check("t5_drop_cnt", DROP_CNT, 0);
`endif

    // Randomized packets, gaps, flag corruption and backpressure
    do_reset();
    rand_ready = 1;
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 11);
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 3) == 0) idle(1);
        ctl = 8'($urandom);
        ctl[0] = (b == 0);
        ctl[1] = (b == len - 1);
        if ($urandom_range(0, 19) == 0) ctl[1:0] = 2'($urandom);
        drive(1, ctl, $urandom, rand_data());
      end
    end
    rand_ready = 0;
    M_AXIS_TREADY = 1;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
